// File: rtl/press_classifier_pkg.sv
// Shared state encoding and sizing helper for the press classifier.
package press_classifier_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_PRESS1 = 3'd1;
    localparam logic [2:0] ST_GAP    = 3'd2;
    localparam logic [2:0] ST_PRESS2 = 3'd3;
    localparam logic [2:0] ST_LONG   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = ST_IDLE,
        StPress1 = ST_PRESS1,
        StGap    = ST_GAP,
        StPress2 = ST_PRESS2,
        StLong   = ST_LONG
    } state_e;

    // One counter serves both the long-press and the gap timeout.
    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = (a > b) ? a : b;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/press_classifier_if.sv
// Bundle of the switch level and the classifier event outputs.
interface press_classifier_if;

    logic Switch;
    logic Short;
    logic Long;
    logic Double;
    logic Held;

    modport master (
        output Switch,
        input  Short,
        input  Long,
        input  Double,
        input  Held
    );

    modport slave (
        input  Switch,
        output Short,
        output Long,
        output Double,
        output Held
    );

endinterface

// File: rtl/press_classifier.sv
// Classifies a debounced switch into short, long and double presses.
module press_classifier
    import press_classifier_pkg::*;
#(
    parameter int unsigned LONG_CLKS = 12500000,
    parameter int unsigned GAP_CLKS  = 5000000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Short,
    output logic o_Long,
    output logic o_Double,
    output logic o_Held
);

    localparam int unsigned CNT_W = cnt_width(LONG_CLKS, GAP_CLKS);
    localparam logic [CNT_W-1:0] LONG_TERM = CNT_W'(LONG_CLKS - 1);
    localparam logic [CNT_W-1:0] GAP_TERM  = CNT_W'(GAP_CLKS - 1);

    state_e           r_state;
    state_e           w_state_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_count_inc;
    logic             r_short;
    logic             r_long;
    logic             r_double;
    logic             r_held;
    logic             w_short_next;
    logic             w_long_next;
    logic             w_double_next;
    logic             w_held_next;

    // Saturating increment so the counter can never wrap.
    assign w_count_inc = (r_count == '1) ? r_count : r_count + 1'b1;

    always_comb begin
        w_state_next  = r_state;
        w_count_next  = r_count;
        w_short_next  = 1'b0;
        w_long_next   = 1'b0;
        w_double_next = 1'b0;

        case (r_state)
            StIdle: begin
                if (i_Switch) w_state_next = StPress1;
            end
            StPress1: begin
                if (i_Switch && (r_count == LONG_TERM)) begin
                    w_state_next = StLong;
                    w_long_next  = 1'b1;
                end else if (!i_Switch) begin
                    w_state_next = StGap;
                end else begin
                    w_count_next = w_count_inc;
                end
            end
            StGap: begin
                // A new rise wins over the timeout on the terminal cycle.
                if (i_Switch) begin
                    w_state_next = StPress2;
                end else if (r_count == GAP_TERM) begin
                    w_state_next = StIdle;
                    w_short_next = 1'b1;
                end else begin
                    w_count_next = w_count_inc;
                end
            end
            StPress2: begin
                if (!i_Switch) begin
                    w_state_next  = StIdle;
                    w_double_next = 1'b1;
                end
            end
            StLong: begin
                if (!i_Switch) w_state_next = StIdle;
            end
            default: w_state_next = StIdle;
        endcase

        if (w_state_next != r_state) w_count_next = '0;
        w_held_next = (w_state_next == StLong);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state  <= StIdle;
            r_count  <= '0;
            r_short  <= 1'b0;
            r_long   <= 1'b0;
            r_double <= 1'b0;
            r_held   <= 1'b0;
        end else begin
            r_state  <= w_state_next;
            r_count  <= w_count_next;
            r_short  <= w_short_next;
            r_long   <= w_long_next;
            r_double <= w_double_next;
            r_held   <= w_held_next;
        end
    end

    assign o_Short  = r_short;
    assign o_Long   = r_long;
    assign o_Double = r_double;
    assign o_Held   = r_held;

endmodule

// File: tb/tb_press_classifier.sv
// Directed bench for press_classifier with LONG_CLKS=8, GAP_CLKS=4.
module tb_press_classifier;

    logic i_Clk = 1'b0;
    logic i_Rst_L;

    press_classifier_if pc_if ();

    press_classifier #(
        .LONG_CLKS (8),
        .GAP_CLKS  (4)
    ) dut (
        .i_Clk    (i_Clk),
        .i_Rst_L  (i_Rst_L),
        .i_Switch (pc_if.Switch),
        .o_Short  (pc_if.Short),
        .o_Long   (pc_if.Long),
        .o_Double (pc_if.Double),
        .o_Held   (pc_if.Held)
    );

    always #5 i_Clk = ~i_Clk;

    int checks = 0;
    int errors = 0;
    int cyc;
    int n_short, n_long, n_double, n_held, n_multi;
    int t_short, t_long, t_double, held_first, held_last;
    int fall_at, rel_at;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        cyc = 0;
        n_short = 0; n_long = 0; n_double = 0; n_held = 0;
        t_short = -1; t_long = -1; t_double = -1;
        held_first = -1; held_last = -1;
    endtask

    // Drive a level for n cycles; sample outputs on the falling edge after each rising edge.
    task automatic drive(input logic level, input int n);
        for (int i = 0; i < n; i++) begin
            pc_if.Switch = level;
            @(negedge i_Clk);
            cyc++;
            if (pc_if.Short)  begin n_short++;  t_short  = cyc; end
            if (pc_if.Long)   begin n_long++;   t_long   = cyc; end
            if (pc_if.Double) begin n_double++; t_double = cyc; end
            if (pc_if.Held) begin
                if (n_held == 0) held_first = cyc;
                n_held++;
                held_last = cyc;
            end
            if (int'(pc_if.Short) + int'(pc_if.Long) + int'(pc_if.Double) > 1) n_multi++;
        end
    endtask

    task automatic settle();
        drive(1'b0, 10);
        clear_mon();
    endtask

    initial begin
        n_multi = 0;
        clear_mon();
        pc_if.Switch = 1'b0;
        i_Rst_L = 1'b0;

        // Reset state
        drive(1'b0, 2);
        chk("rst_short",  int'(pc_if.Short),  0);
        chk("rst_long",   int'(pc_if.Long),   0);
        chk("rst_double", int'(pc_if.Double), 0);
        chk("rst_held",   int'(pc_if.Held),   0);
        i_Rst_L = 1'b1;
        settle();

        // Short press: high 3, then low; short at fall+5
        drive(1'b1, 3);
        fall_at = cyc;
        drive(1'b0, 8);
        chk("s1_n_short",  n_short, 1);
        chk("s1_t_short",  t_short, fall_at + 5);
        chk("s1_n_long",   n_long, 0);
        chk("s1_n_double", n_double, 0);
        chk("s1_n_held",   n_held, 0);
        settle();

        // Long press held 20 cycles
        drive(1'b1, 20);
        fall_at = cyc;
        drive(1'b0, 10);
        chk("s2_n_long",      n_long, 1);
        chk("s2_t_long",      t_long, 9);
        chk("s2_held_first",  held_first, 9);
        chk("s2_held_last",   held_last, fall_at);
        chk("s2_n_held",      n_held, fall_at - 8);
        chk("s2_n_short",     n_short, 0);
        chk("s2_n_double",    n_double, 0);
        settle();

        // Double press: high 3, low 2, high 3, low
        drive(1'b1, 3);
        drive(1'b0, 2);
        drive(1'b1, 3);
        fall_at = cyc;
        drive(1'b0, 8);
        chk("s3_n_double", n_double, 1);
        chk("s3_t_double", t_double, fall_at + 1);
        chk("s3_n_short",  n_short, 0);
        chk("s3_n_long",   n_long, 0);
        settle();

        // Second rise lands on the gap terminal cycle: double wins
        drive(1'b1, 3);
        drive(1'b0, 4);
        drive(1'b1, 2);
        fall_at = cyc;
        drive(1'b0, 8);
        chk("s4_n_double", n_double, 1);
        chk("s4_t_double", t_double, fall_at + 1);
        chk("s4_n_short",  n_short, 0);
        settle();

        // Reset mid-PRESS1 with switch held high
        drive(1'b1, 5);
        i_Rst_L = 1'b0;
        drive(1'b1, 2);
        chk("s5_rst_long", int'(pc_if.Long), 0);
        chk("s5_rst_held", int'(pc_if.Held), 0);
        chk("s5_rst_n_long", n_long, 0);
        i_Rst_L = 1'b1;
        rel_at = cyc;
        drive(1'b1, 12);
        chk("s5_n_long", n_long, 1);
        chk("s5_t_long", t_long, rel_at + 9);

        // Reset while held clears o_Held without a clock edge
        chk("s6_held_before", int'(pc_if.Held), 1);
        i_Rst_L = 1'b0;
        #1;
        chk("s6_held_async", int'(pc_if.Held), 0);
        @(negedge i_Clk);
        pc_if.Switch = 1'b0;
        i_Rst_L = 1'b1;
        settle();

        // Boundary: the entry cycle moves IDLE->PRESS1, so 8 high samples stay short
        drive(1'b1, 8);
        fall_at = cyc;
        drive(1'b0, 8);
        chk("s7_short_n_short", n_short, 1);
        chk("s7_short_t_short", t_short, fall_at + 5);
        chk("s7_short_n_long",  n_long, 0);
        settle();

        // One more high sample reaches the long terminal count
        drive(1'b1, 9);
        drive(1'b0, 8);
        chk("s7_long_n_long",  n_long, 1);
        chk("s7_long_t_long",  t_long, 9);
        chk("s7_long_n_short", n_short, 0);

        chk("pulse_exclusive", n_multi, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
